mix_vga_control_decode: RTL and testbench

- Receive-side counterpart of the VGA-control thermometer encoder. Takes the 6-bit thermometer-coded control bus (value k is sent as k ones, LSB-first) and recovers the 3-bit level.
- Synchronises the bus, rejects bubble codes, and commits a level only after it has been stable for a set number of cycles.
- Flags faults and counts corrupt samples. Sits at the mix block's receive side, ahead of the VGA mixing logic.

---
 rtl/mix_vga_control_decode.sv | 172 +++++++++++++++++
 tb/tb_mix_vga_control_decode.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mix_vga_control_decode.sv
// -----------------------------------------------------------------------------
// mix_vga_control_decode
//
// Receive-side decoder for the thermometer-coded VGA control bus. The bus
// carries level k as k ones packed from the LSB. The block synchronises the
// (possibly asynchronous) bus and sorts each synchronised sample into a valid
// code or a bubble. A code is committed only after it has been held for
// STABLE_CYCLES consecutive synchronised samples.
//
// Ports:
//   clk            - single clock
//   rstn           - asynchronous active-low reset
//   vga_control_in - THERM_WIDTH-bit thermometer bus
//   err_clr        - synchronous clear of err_count (wins over increment)
//   level_out      - committed decoded level (held through a fault)
//   level_valid    - level_out holds a committed valid code
//   level_change   - one-cycle pulse when a new level is committed
//   code_err       - a bubble code has been committed (FAULT state)
//   err_count      - saturating count of cycles whose sample was a bubble
// -----------------------------------------------------------------------------
module mix_vga_control_decode #(
    parameter int THERM_WIDTH   = 6,
    parameter int OUT_WIDTH     = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [THERM_WIDTH-1:0] vga_control_in,
    input  logic                   err_clr,
    output logic [OUT_WIDTH-1:0]   level_out,
    output logic                   level_valid,
    output logic                   level_change,
    output logic                   code_err,
    output logic [7:0]             err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic             SINGLE_CYC = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // Returns {valid, level}: valid when the code is k ones from the LSB.
    function automatic logic [OUT_WIDTH:0] therm_decode(input logic [THERM_WIDTH-1:0] code);
        logic [OUT_WIDTH:0] res;
        res = '0;
        for (int k = 0; k <= THERM_WIDTH; k++) begin
            res = (code == THERM_WIDTH'((1 << k) - 1)) ? {1'b1, OUT_WIDTH'(k)} : res;
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0][THERM_WIDTH-1:0] sync_r;
    logic [THERM_WIDTH-1:0]                  samp_s;
    logic [OUT_WIDTH:0]                      dec_s;
    logic                                    dec_valid_s;
    logic [OUT_WIDTH-1:0]                    dec_level_s;
    logic [THERM_WIDTH-1:0]                  cand_r;
    logic [CNT_W-1:0]                        cnt_r;
    logic                                    commit_s;
    state_t                                  state_r;

    // Synchroniser shift chain; the last stage is the sample used everywhere.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], vga_control_in};
        end
    end

    assign samp_s      = sync_r[SYNC_STAGES-1];
    assign dec_s       = therm_decode(samp_s);
    assign dec_valid_s = dec_s[OUT_WIDTH];
    assign dec_level_s = dec_s[OUT_WIDTH-1:0];

    // A commit fires on the edge where the run length of identical samples
    // reaches STABLE_CYCLES; a new sample starts a run of length one.
    always_comb begin
        commit_s = 1'b0;
        if (samp_s != cand_r) begin
            commit_s = SINGLE_CYC;
        end else begin
            commit_s = (cnt_r == CNT_PRE);
        end
    end

    // Stability filter: candidate code and saturating run-length counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cand_r <= '0;
            cnt_r  <= '0;
        end else if (samp_s != cand_r) begin
            cand_r <= samp_s;
            cnt_r  <= CNT_ONE;
        end else if (cnt_r < CNT_MAX) begin
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    // Control FSM with registered outputs, acting only on commit events.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_ACQUIRE;
            level_out    <= '0;
            level_valid  <= 1'b0;
            level_change <= 1'b0;
            code_err     <= 1'b0;
        end else begin
            level_change <= 1'b0;
            if (commit_s) begin
                case (state_r)
                    ST_ACQUIRE, ST_FAULT: begin
                        if (dec_valid_s) begin
                            state_r      <= ST_LOCKED;
                            level_out    <= dec_level_s;
                            level_valid  <= 1'b1;
                            level_change <= 1'b1;
                            code_err     <= 1'b0;
                        end else begin
                            state_r      <= ST_FAULT;
                            level_valid  <= 1'b0;
                            code_err     <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!dec_valid_s) begin
                            state_r      <= ST_FAULT;
                            level_valid  <= 1'b0;
                            code_err     <= 1'b1;
                        end else if (dec_level_s != level_out) begin
                            level_out    <= dec_level_s;
                            level_change <= 1'b1;
                        end else begin
                            level_out    <= level_out;
                        end
                    end
                    default: begin
                        state_r      <= ST_ACQUIRE;
                        level_valid  <= 1'b0;
                        code_err     <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Bubble counter: counts raw bubble samples, saturates, clear has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count <= 8'd0;
        end else if (err_clr) begin
            err_count <= 8'd0;
        end else if (!dec_valid_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end else begin
            err_count <= err_count;
        end
    end

endmodule

// File: tb/tb_mix_vga_control_decode.sv
module tb_mix_vga_control_decode;

    localparam int TW     = 6;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [TW-1:0] vga_control_in = '0;
    logic          err_clr = 1'b0;
    logic [2:0]    level_out;
    logic          level_valid;
    logic          level_change;
    logic          code_err;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [TW-1:0] hist[$];
    logic [TW-1:0] prev_s;
    bit            have_prev;
    int            run_len;
    int            exp_level, exp_valid, exp_change, exp_err, exp_cnt;

    mix_vga_control_decode dut (
        .clk            (clk),
        .rstn           (rstn),
        .vga_control_in (vga_control_in),
        .err_clr        (err_clr),
        .level_out      (level_out),
        .level_valid    (level_valid),
        .level_change   (level_change),
        .code_err       (code_err),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        have_prev  = 0;
        run_len    = 0;
        exp_level  = 0;
        exp_valid  = 0;
        exp_change = 0;
        exp_err    = 0;
        exp_cnt    = 0;
    endtask

    // One clock edge of the reference: s is the input seen SYNC edges ago,
    // a level commits when its run of identical samples reaches STABLE.
    task automatic model_step(input logic [TW-1:0] din, input logic clr);
        int  sv;
        int  lvl;
        bit  valid;
        logic [TW-1:0] s;
        s = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : '0;
        hist.push_back(din);
        if (hist.size() > 8) void'(hist.pop_front());
        if (!have_prev || s != prev_s) run_len = 1;
        else if (run_len < 1000) run_len++;
        have_prev = 1;
        prev_s    = s;
        sv    = int'(s);
        valid = ((sv & (sv + 1)) == 0);
        lvl   = $countones(s);
        exp_change = 0;
        if (run_len == STABLE) begin
            if (valid) begin
                if (!exp_valid || exp_level != lvl) exp_change = 1;
                exp_level = lvl;
                exp_valid = 1;
                exp_err   = 0;
            end else begin
                exp_valid = 0;
                exp_err   = 1;
            end
        end
        if (clr) exp_cnt = 0;
        else if (!valid && exp_cnt < 255) exp_cnt++;
    endtask

    // Model update on every active edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rstn) model_reset();
            else model_step(vga_control_in, err_clr);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                chk("level_out",    int'(level_out),    exp_level);
                chk("level_valid",  int'(level_valid),  exp_valid);
                chk("level_change", int'(level_change), exp_change);
                chk("code_err",     int'(code_err),     exp_err);
                chk("err_count",    int'(err_count),    exp_cnt);
            end
        end
    end

    task automatic hold(input logic [TW-1:0] val, input int n, input bit rnd_clr);
        vga_control_in = val;
        for (int i = 0; i < n; i++) begin
            err_clr = rnd_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
            @(negedge clk);
        end
        err_clr = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] v;
        int            k;
        repeat (3) @(negedge clk);
        chk("rst_level",  int'(level_out), 0);
        chk("rst_valid",  int'(level_valid), 0);
        chk("rst_change", int'(level_change), 0);
        chk("rst_err",    int'(code_err), 0);
        chk("rst_cnt",    int'(err_count), 0);

        // first acquire: commit exactly six edges after first sample
        rstn = 1'b1;
        vga_control_in = 6'b000111;
        repeat (5) @(negedge clk);
        chk("lat_not_yet", int'(level_valid), 0);
        @(negedge clk);
        chk("lat_level",  int'(level_out), 3);
        chk("lat_valid",  int'(level_valid), 1);
        chk("lat_pulse",  int'(level_change), 1);
        @(negedge clk);
        chk("lat_pulse_end", int'(level_change), 0);

        // short glitch rejected, then a held change commits
        hold(6'b011111, 3, 1'b0);
        hold(6'b000111, 10, 1'b0);
        chk("glitch_level", int'(level_out), 3);
        hold(6'b011111, 10, 1'b0);
        chk("lvl5", int'(level_out), 5);

        // bubble fault: level held, valid dropped, bubble count
        hold(6'b000101, 10, 1'b0);
        chk("fault_err",   int'(code_err), 1);
        chk("fault_valid", int'(level_valid), 0);
        chk("fault_level", int'(level_out), 5);
        chk("fault_cnt",   int'(err_count), 8);
        hold(6'b111111, 10, 1'b0);
        chk("recover_level", int'(level_out), 6);
        chk("recover_err",   int'(code_err), 0);

        // saturation and clear-wins
        hold(6'b101010, 300, 1'b0);
        chk("sat_cnt", int'(err_count), 255);
        err_clr = 1'b1;
        @(negedge clk);
        chk("clr_cnt", int'(err_count), 0);
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_resume", int'(err_count), 1);

        hold(6'b111111, 10, 1'b0);
        hold(6'b000000, 10, 1'b0);
        chk("zero_level", int'(level_out), 0);
        chk("zero_valid", int'(level_valid), 1);

        // asynchronous reset between edges
        vga_control_in = 6'b000011;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_level",  int'(level_out), 0);
        chk("arst_valid",  int'(level_valid), 0);
        chk("arst_change", int'(level_change), 0);
        chk("arst_err",    int'(code_err), 0);
        chk("arst_cnt",    int'(err_count), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("rearm_not_yet", int'(level_valid), 0);
        @(negedge clk);
        chk("rearm_level", int'(level_out), 2);
        chk("rearm_valid", int'(level_valid), 1);

        // randomized segments: valid codes, bubbles, short glitches
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, TW);
                v = TW'((1 << k) - 1);
            end else begin
                v = TW'($urandom);
            end
            hold(v, $urandom_range(1, 9), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
